uart_word_assembler: RTL and testbench

//  Parametrised successor to the byte-to-word collector on the UART receive path.
//  - Packs N/8 received UART bytes into one N-bit word, MSB-first or LSB-first.
//  - Presents the word on a valid/ready output with backpressure.
//  - Abandons a partial word on an inter-byte timeout or on a receive error.

---
 rtl/uart_word_assembler_pkg.sv | 11 +
 rtl/uart_word_assembler_idle_timer.sv | 19 +
 rtl/uart_word_assembler.sv | 73 +++++++
 tb/tb_uart_word_assembler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uart_word_assembler_pkg.sv
// uart_word_assembler_pkg: shared byte width, FSM encodings and width helper
package uart_word_assembler_pkg;
  localparam int BYTE_W = 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_word_assembler_idle_timer.sv
// uart_word_assembler_idle_timer: reloadable down-counter that pulses expire after LIMIT idle cycles
module uart_word_assembler_idle_timer
  import uart_word_assembler_pkg::*;
#(
  parameter int LIMIT = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = clog2(LIMIT + 1) < 1 ? 1 : clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clear || !enable) cnt <= W'(LIMIT);
    else cnt <= cnt - W'(1);
  assign expire = (LIMIT != 0) && enable && !clear && cnt == W'(1);
endmodule

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs N/8 UART bytes into an N-bit word on a valid/ready output
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int N = 32,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT_CYCLES = 12000,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_error,
  output logic [N-1:0]     word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] bytes_pending,
  output logic             overrun,
  output logic             timeout
);
  logic [0:0] state;
  logic [N-1:0] sh, sh_next;
  logic last, expire;
  assign sh_next = MSB_FIRST ? ((sh << BYTE_W) | N'(rx_byte))
                             : ((sh >> BYTE_W) | (N'(rx_byte) << (N - BYTE_W)));
  assign last = bytes_pending == CNT_W'(N / BYTE_W - 1);
  uart_word_assembler_idle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(rx_valid | rx_error),
    .enable(state == ST_COLLECT),
    .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sh <= '0;
      bytes_pending <= '0;
      word_data <= '0;
      word_valid <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      if (word_valid && word_ready) word_valid <= 1'b0;
      if (rx_error) begin
        state <= ST_IDLE;
        sh <= '0;
        bytes_pending <= '0;
      end else if (rx_valid && last) begin
        state <= ST_IDLE;
        sh <= '0;
        bytes_pending <= '0;
        // a completed word only loads if the slot is free or being drained this cycle
        if (!word_valid || word_ready) begin
          word_data <= sh_next;
          word_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (rx_valid) begin
        state <= ST_COLLECT;
        sh <= sh_next;
        bytes_pending <= bytes_pending + CNT_W'(1);
      end else if (expire) begin
        state <= ST_IDLE;
        sh <= '0;
        bytes_pending <= '0;
        timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_word_assembler.sv
// tb_uart_word_assembler: directed checks of MSB-first and LSB-first assemblers driven in parallel
module tb_uart_word_assembler;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, rx_error = 1'b0, word_ready = 1'b1;
  logic [7:0] rx_byte = '0;
  logic [31:0] data_m, data_l;
  logic valid_m, valid_l, ovr_m, ovr_l, to_m, to_l;
  logic [2:0] pend_m, pend_l;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_word_assembler #(.N(32), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16), .CNT_W(3)) dut_m (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .word_data(data_m), .word_valid(valid_m), .word_ready(word_ready),
    .bytes_pending(pend_m), .overrun(ovr_m), .timeout(to_m)
  );
  uart_word_assembler #(.N(32), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(16), .CNT_W(3)) dut_l (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .word_data(data_l), .word_valid(valid_l), .word_ready(word_ready),
    .bytes_pending(pend_l), .overrun(ovr_l), .timeout(to_l)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte = b;
    step();
    rx_valid = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_data", data_m, 32'h0);
    chk("rst_pend", 32'(pend_m), 32'd0);
    chk("rst_ovr_to", 32'({ovr_m, to_m}), 32'd0);
    rst_n = 1'b1;
    send(8'hDE); send(8'hAD); send(8'hBE);
    chk("t1_pend3", 32'(pend_m), 32'd3);
    chk("t1_valid_early", 32'(valid_m), 32'd0);
    send(8'hEF);
    chk("t1_valid", 32'(valid_m), 32'd1);
    chk("t1_msb_data", data_m, 32'hDEADBEEF);
    chk("t2_lsb_data", data_l, 32'hEFBEADDE);
    chk("t1_pend0", 32'(pend_m), 32'd0);
    step();
    chk("t1_valid_drop", 32'(valid_m), 32'd0);
    word_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t3_first", data_m, 32'h01020304);
    send(8'h05); send(8'h06); send(8'h07);
    chk("t3_no_ovr_yet", 32'(ovr_m), 32'd0);
    send(8'h08);
    chk("t3_ovr", 32'(ovr_m), 32'd1);
    chk("t3_held", data_m, 32'h01020304);
    chk("t3_held_valid", 32'(valid_m), 32'd1);
    step();
    chk("t3_ovr_pulse", 32'(ovr_m), 32'd0);
    send(8'h05); send(8'h06); send(8'h07);
    word_ready = 1'b1;
    send(8'h08);
    chk("t3_load", data_m, 32'h05060708);
    chk("t3_load_valid", 32'(valid_m), 32'd1);
    chk("t3_load_no_ovr", 32'(ovr_m), 32'd0);
    step();
    chk("t3_drain", 32'(valid_m), 32'd0);
    send(8'hA1); send(8'hA2);
    chk("t4_pend2", 32'(pend_m), 32'd2);
    step(15);
    chk("t4_not_yet", 32'(to_m), 32'd0);
    chk("t4_pend_kept", 32'(pend_m), 32'd2);
    step();
    chk("t4_timeout", 32'(to_m), 32'd1);
    chk("t4_pend_clr", 32'(pend_m), 32'd0);
    step();
    chk("t4_to_pulse", 32'(to_m), 32'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t4_word", data_m, 32'h11223344);
    send(8'hB1);
    step(15);
    send(8'hB2);
    chk("t4_edge_kept", 32'(pend_m), 32'd2);
    chk("t4_edge_no_to", 32'(to_m), 32'd0);
    step(16);
    chk("t4_edge_timeout", 32'(to_m), 32'd1);
    send(8'h61); send(8'h62); send(8'h63);
    rx_error = 1'b1;
    send(8'h55);
    rx_error = 1'b0;
    chk("t5_pend0", 32'(pend_m), 32'd0);
    chk("t5_no_word", 32'(valid_m), 32'd0);
    word_ready = 1'b0;
    send(8'h71); send(8'h72); send(8'h73); send(8'h74);
    chk("t5_clean", data_m, 32'h71727374);
    chk("t5_clean_lsb", data_l, 32'h74737271);
    rx_error = 1'b1;
    step();
    rx_error = 1'b0;
    chk("t5_err_keeps_valid", 32'(valid_m), 32'd1);
    chk("t5_err_keeps_data", data_m, 32'h71727374);
    word_ready = 1'b1;
    step();
    send(8'h81); send(8'h82);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_pend", 32'(pend_m), 32'd0);
    word_ready = 1'b0;
    send(8'h91); send(8'h92); send(8'h93); send(8'h94);
    chk("t6_word", data_m, 32'h91929394);
    rst_n = 1'b0;
    send(8'hEE);
    rst_n = 1'b1;
    chk("t6_rst_valid", 32'(valid_m), 32'd0);
    chk("t6_rst_data", data_m, 32'h0);
    chk("t6_rst_ignores_rx", 32'(pend_m), 32'd0);
    word_ready = 1'b1;
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    chk("t6_after", data_m, 32'hC1C2C3C4);
    chk("t6_after_valid", 32'(valid_m), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
